// File: rtl/code_locker.sv
// code_locker: serial two-button combination lock.
// Digits arrive one per valid press (exactly one button high). A full entry
// of CODE_LEN digits either opens the lock for UNLOCK_CYCLES cycles or counts
// as a failed attempt. While open, code_load replaces the stored combination.
// Optional feature macro LOCKER_LOCKOUT_EN: after MAX_FAILS consecutive failed
// entries, entry is disabled for LOCKOUT_CYCLES cycles.
module code_locker #(
    parameter int                  CODE_LEN       = 5,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 16,
    parameter int                  UNLOCK_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button_0,
    input  logic                button_1,
    input  logic                code_load,
    input  logic [CODE_LEN-1:0] code_in,
    output logic                unlock,
    output logic                lockout,
    output logic [3:0]          fail_cnt
);

    localparam int IDX_W   = $clog2(CODE_LEN);
    localparam int TMAX    = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(CODE_LEN - 1);
    localparam logic [TIMER_W-1:0] UNLOCK_LAST = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [3:0]         FAIL_MAX    = 4'(MAX_FAILS);

    localparam logic [1:0] ST_ENTRY  = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
`ifdef LOCKER_LOCKOUT_EN
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
`endif

    logic [1:0]          state, state_n;
    logic [IDX_W-1:0]    index, index_n;
    logic                mismatch, mismatch_n;
    logic [3:0]          fail_n;
    logic [CODE_LEN-1:0] stored_code, stored_n;
    logic [TIMER_W-1:0]  timer, timer_n;
    logic                press;
    logic                digit;

    // A press is exactly one button high; button_1 carries the digit value.
    assign press = button_0 ^ button_1;
    assign digit = button_1;

    // Next-state logic: digit collection, open timing, code load, lockout.
    always_comb begin
        state_n    = state;
        index_n    = index;
        mismatch_n = mismatch;
        fail_n     = fail_cnt;
        stored_n   = stored_code;
        timer_n    = timer;
        case (state)
            ST_ENTRY: begin
                if (press) begin
                    if (index == LAST_IDX) begin
                        // Final digit: judge the whole entry and restart collection.
                        index_n    = '0;
                        mismatch_n = 1'b0;
                        if (!mismatch && (digit == stored_code[index])) begin
                            state_n = ST_OPEN;
                            timer_n = '0;
                            fail_n  = 4'd0;
                        end else begin
                            if (fail_cnt != FAIL_MAX) begin
                                fail_n = fail_cnt + 4'd1;
                            end
`ifdef LOCKER_LOCKOUT_EN
                            if (fail_n == FAIL_MAX) begin
                                state_n = ST_LOCKED;
                                timer_n = '0;
                            end
`endif
                        end
                    end else begin
                        index_n    = index + 1'b1;
                        mismatch_n = mismatch | (digit != stored_code[index]);
                    end
                end
            end
            ST_OPEN: begin
                // A load wins over presses and over the hold-time expiry.
                if (code_load) begin
                    stored_n = code_in;
                    state_n  = ST_ENTRY;
                    timer_n  = '0;
                end else if (timer == UNLOCK_LAST) begin
                    state_n = ST_ENTRY;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`ifdef LOCKER_LOCKOUT_EN
            ST_LOCKED: begin
                if (timer == LOCKOUT_LAST) begin
                    state_n = ST_ENTRY;
                    timer_n = '0;
                    fail_n  = 4'd0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`endif
            default: begin
                state_n = ST_ENTRY;
                timer_n = '0;
            end
        endcase
    end

    // State and datapath registers; Moore outputs decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ENTRY;
            index       <= '0;
            mismatch    <= 1'b0;
            fail_cnt    <= 4'd0;
            stored_code <= DEFAULT_CODE;
            timer       <= '0;
            unlock      <= 1'b0;
        end else begin
            state       <= state_n;
            index       <= index_n;
            mismatch    <= mismatch_n;
            fail_cnt    <= fail_n;
            stored_code <= stored_n;
            timer       <= timer_n;
            unlock      <= (state_n == ST_OPEN);
        end
    end

`ifdef LOCKER_LOCKOUT_EN
    // Lockout flag registered alongside the state it mirrors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockout <= 1'b0;
        end else begin
            lockout <= (state_n == ST_LOCKED);
        end
    end
`else
    assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_code_locker.sv
// Testbench for code_locker: directed digit sequences, an entry-level
// behavioural model checked every cycle, plus literal expectations.
module tb_code_locker;

    localparam int         CODE_LEN = 5;
    localparam logic [4:0] DEF_CODE = 5'b01011;
    localparam int         MAXF     = 3;
    localparam int         LOCK_CYC = 16;
    localparam int         OPEN_CYC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button_0 = 1'b0;
    logic       button_1 = 1'b0;
    logic       code_load = 1'b0;
    logic [4:0] code_in = 5'b0;
    logic       unlock;
    logic       lockout;
    logic [3:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    code_locker dut (
        .clk      (clk),
        .rst      (rst),
        .button_0 (button_0),
        .button_1 (button_1),
        .code_load(code_load),
        .code_in  (code_in),
        .unlock   (unlock),
        .lockout  (lockout),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (entry-level view) ----------------
    bit         m_q[$];
    int         m_open_left = 0;
    int         m_lock_left = 0;
    int         m_fails = 0;
    logic [4:0] m_code = DEF_CODE;
`ifdef LOCKER_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_open_left = 0;
            m_lock_left = 0;
            m_fails     = 0;
            m_code      = DEF_CODE;
        end else if (m_open_left > 0) begin
            if (code_load) begin
                m_code      = code_in;
                m_open_left = 0;
            end else begin
                m_open_left = m_open_left - 1;
            end
        end else if (m_lock_left > 0) begin
            m_lock_left = m_lock_left - 1;
            if (m_lock_left == 0) m_fails = 0;
        end else if (button_0 != button_1) begin
            m_q.push_back(button_1);
            if (m_q.size() == CODE_LEN) begin
                logic [4:0] w;
                for (int i = 0; i < CODE_LEN; i++) w[i] = m_q[i];
                m_q.delete();
                if (w == m_code) begin
                    m_open_left = OPEN_CYC;
                    m_fails     = 0;
                end else begin
                    if (m_fails < MAXF) m_fails = m_fails + 1;
                    if (LOCK_EN && m_fails == MAXF) m_lock_left = LOCK_CYC;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("cyc_unlock", int'(unlock), int'(m_open_left > 0));
        chk("cyc_lockout", int'(lockout), int'(m_lock_left > 0));
        chk("cyc_fail_cnt", int'(fail_cnt), m_fails);
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input bit d);
        @(negedge clk);
        button_0 = ~d;
        button_1 = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            button_0  = 1'b0;
            button_1  = 1'b0;
            code_load = 1'b0;
        end
    endtask

    task automatic enter(input logic [4:0] w);
        for (int i = 0; i < CODE_LEN; i++) press(w[i]);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [4:0] dflt;
        dflt = DEF_CODE;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_unlock", int'(unlock), 0);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Default code 1,1,0,1,0 opens for exactly 8 cycles
        enter(5'b01011);
        after_edge();
        chk("default_unlock", int'(unlock), 1);
        chk("default_fail_cnt", int'(fail_cnt), 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            button_0 = 1'b0;
            button_1 = 1'b0;
            if (unlock) cnt++;
        end
        chk("unlock_width", cnt, 8);

        // Wrong code then correct code
        enter(5'b01010);
        after_edge();
        chk("wrong_unlock", int'(unlock), 0);
        chk("wrong_fail_cnt", int'(fail_cnt), 1);
        idle(1);
        enter(5'b01011);
        after_edge();
        chk("retry_unlock", int'(unlock), 1);
        chk("retry_fail_cnt", int'(fail_cnt), 0);
        idle(10);

        // No-press filtering interleaved with the correct sequence
        press(1'b1);
        @(negedge clk); button_0 = 1'b1; button_1 = 1'b1;
        press(1'b1);
        @(negedge clk); button_0 = 1'b0; button_1 = 1'b0;
        press(1'b0);
        @(negedge clk); button_0 = 1'b1; button_1 = 1'b1;
        press(1'b1);
        idle(2);
        after_edge();
        chk("filter_before_last", int'(unlock), 0);
        press(1'b0);
        after_edge();
        chk("filter_unlock", int'(unlock), 1);
        idle(10);

        // Code change with a simultaneous press
        enter(5'b01011);
        @(negedge clk);
        code_load = 1'b1;
        code_in   = 5'b11111;
        button_0  = 1'b0;
        button_1  = 1'b1;
        after_edge();
        chk("load_exit_open", int'(unlock), 0);
        idle(1);
        enter(5'b11111);
        after_edge();
        chk("new_code_unlock", int'(unlock), 1);
        idle(10);
        enter(5'b01011);
        after_edge();
        chk("old_code_fail", int'(fail_cnt), 1);
        chk("old_code_unlock", int'(unlock), 0);
        idle(1);

        // Load on the last open cycle is still honoured
        enter(5'b11111);
        idle(7);
        @(negedge clk);
        code_load = 1'b1;
        code_in   = 5'b00110;
        idle(1);
        enter(5'b00110);
        after_edge();
        chk("last_cycle_load", int'(unlock), 1);
        chk("last_cycle_fail", int'(fail_cnt), 0);
        idle(2);

        // Asynchronous reset while open
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_unlock", int'(unlock), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-entry after 3 correct digits; loaded code is lost
        press(1'b1);
        press(1'b1);
        press(1'b0);
        idle(1);
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        press(dflt[3]);
        press(dflt[4]);
        idle(1);
        after_edge();
        chk("midentry_no_unlock", int'(unlock), 0);
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enter(5'b00110);
        after_edge();
        chk("lost_code_fail", int'(fail_cnt), 1);
        idle(1);
        enter(5'b01011);
        after_edge();
        chk("post_rst_unlock", int'(unlock), 1);
        idle(10);

`ifdef LOCKER_LOCKOUT_EN
        // Three failures lock out entry for 16 cycles
        enter(5'b00000); idle(1);
        enter(5'b00000); idle(1);
        enter(5'b00000);
        after_edge();
        chk("lock_lockout", int'(lockout), 1);
        chk("lock_fail_cnt", int'(fail_cnt), 3);
        cnt = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i < CODE_LEN) begin
                button_0 = ~dflt[i];
                button_1 = dflt[i];
            end else begin
                button_0 = 1'b0;
                button_1 = 1'b0;
            end
            if (lockout) cnt++;
            if (unlock) cnt += 100;
        end
        chk("lockout_width", cnt, 16);
        chk("lock_exit_fail_cnt", int'(fail_cnt), 0);
        enter(5'b01011);
        after_edge();
        chk("lock_exit_unlock", int'(unlock), 1);
        idle(10);
`else
        // Without lockout, failures saturate and entry stays available
        for (int k = 0; k < 4; k++) begin
            enter(5'b00000);
            idle(1);
        end
        after_edge();
        chk("sat_fail_cnt", int'(fail_cnt), 3);
        chk("sat_lockout", int'(lockout), 0);
        enter(5'b01011);
        after_edge();
        chk("sat_unlock", int'(unlock), 1);
        chk("sat_clear", int'(fail_cnt), 0);
        idle(10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/code_locker.md
CODE_LOCKER -- requirements
Module: code_locker

Interface
REQ-001 Parameter CODE_LEN, default 5: number of digits in the combination (2..16).
REQ-002 Parameter DEFAULT_CODE, default 5'b01011: reset combination; bit i is the expected digit for press i, bit 0 first.
REQ-003 Parameter MAX_FAILS, default 3: consecutive failed entries that trigger lockout (1..15).
REQ-004 Parameter LOCKOUT_CYCLES, default 16: lockout duration in clk cycles (>=1).
REQ-005 Parameter UNLOCK_CYCLES, default 8: unlock hold duration in clk cycles (>=1).
REQ-006 Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- button_0  input  1  digit-0 press; sampled each rising edge.
- button_1  input  1  digit-1 press; sampled each rising edge.
- code_load  input  1  request to replace the stored combination.
- code_in  input  CODE_LEN  new combination; bit i is the digit for press i.
- unlock  output  1  lock open (Moore, registered).
- lockout  output  1  entry disabled after repeated failures (Moore, registered).
- fail_cnt  output  4  count of consecutive failed entries.

Function
REQ-007 A valid press SHALL be exactly one of button_0/button_1 high in a cycle; both high or both low SHALL be no press and SHALL NOT advance the digit counter.
REQ-008 The FSM SHALL have three states: ENTRY, OPEN and LOCKED. Outputs SHALL be unlock=(state==OPEN) and lockout=(state==LOCKED).
REQ-009 In ENTRY, each valid press SHALL increment the digit index. A mismatch flag SHALL be set if the pressed digit differs from stored_code[index].
REQ-010 On the edge sampling press CODE_LEN with no mismatch, the FSM SHALL enter OPEN, so unlock is high from that edge. The index and mismatch flag SHALL clear, and fail_cnt SHALL clear to 0.
REQ-011 On the edge sampling press CODE_LEN with a mismatch, the index and mismatch flag SHALL clear and fail_cnt SHALL increment. The FSM SHALL stay in ENTRY unless the new count equals MAX_FAILS.
REQ-012 OPEN SHALL last exactly UNLOCK_CYCLES cycles, then return to ENTRY. Presses in OPEN SHALL be ignored.
REQ-013 code_load SHALL be honoured only in OPEN. It SHALL latch code_in into stored_code and force ENTRY on the same edge. code_load in ENTRY or LOCKED SHALL be ignored.
REQ-014 A press coinciding with code_load in OPEN SHALL be ignored; the load SHALL take effect.
REQ-015 A code_load coinciding with the last OPEN cycle SHALL still be honoured.
REQ-016 fail_cnt SHALL saturate at MAX_FAILS and SHALL never wrap.

Reset
REQ-017 While rst is high, the block SHALL asynchronously hold: state=ENTRY, index=0, mismatch=0, fail_cnt=0, stored_code=DEFAULT_CODE, all timers=0, unlock=0, lockout=0.
REQ-018 Reset asserted mid-entry, in OPEN or in LOCKED SHALL abandon that activity immediately. Any loaded code SHALL revert to DEFAULT_CODE.
REQ-019 Operation SHALL resume on the first rising clk edge after rst deasserts.

Configuration
REQ-020 Macro LOCKER_LOCKOUT_EN defined: on the edge where fail_cnt reaches MAX_FAILS, the FSM SHALL enter LOCKED for LOCKOUT_CYCLES cycles. Presses SHALL be ignored during LOCKED. On exit the FSM SHALL go to ENTRY with fail_cnt=0.
REQ-021 Macro LOCKER_LOCKOUT_EN undefined: LOCKED and its timer SHALL be absent and lockout SHALL be tied 0. fail_cnt SHALL still count and saturate per REQ-016, and presses SHALL always be accepted.

Verification
REQ-022 Default code check: reset, then digits 1,1,0,1,0 on successive negedges -> unlock rises on the edge sampling the 5th press, stays high for 8 cycles, fail_cnt=0.
REQ-023 Wrong code: digits 0,1,0,1,0 -> unlock stays 0 and fail_cnt=1 after the 5th press. A following correct 1,1,0,1,0 -> unlock=1 and fail_cnt=0.
REQ-024 No-press filtering: both buttons high, or both low, interleaved with the correct sequence -> ignored. Unlock timing SHALL equal the 5-valid-press count.
REQ-025 Code change: unlock, pulse code_load with code_in=5'b11111 -> back to ENTRY. 1,1,1,1,1 -> unlock; 1,1,0,1,0 -> fail.
REQ-026 With LOCKER_LOCKOUT_EN: 3 wrong entries -> lockout=1 for 16 cycles, correct code during lockout does not unlock. After exit, fail_cnt=0 and the correct code unlocks.
REQ-027 Reset mid-entry after 3 correct digits -> index cleared. 5 correct digits are then required; a code loaded before reset is lost.
